// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin arbitration at packet granularity. A grant is held until the owner sends
// a byte flagged last, reaches MAX_BURST bytes, or leaves req_valid low for TIMEOUT_CYC
// consecutive cycles.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last     final byte of packet, qualified by req_valid
//   req_ready    per-requester accept (only the owner may see it high)
//   tx_data      byte to the UART transmitter
//   tx_valid     byte valid to the UART transmitter
//   tx_ready     accept from the UART transmitter
//   grant_id     current owner, meaningful while busy is high
//   busy         grant held
//   timeout_err  one-cycle pulse following a timeout release
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned GrantW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [GrantW-1:0]         grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned IdleW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CandW  = GrantW + 1;

  localparam logic [GrantW-1:0] LastIdx  = GrantW'(NUM_REQ - 1);
  localparam logic [BurstW-1:0] BurstLim = BurstW'(MAX_BURST - 1);
  localparam logic [IdleW-1:0]  IdleLim  = IdleW'(TIMEOUT_CYC - 1);
  localparam logic [IdleW-1:0]  IdleMax  = IdleW'(TIMEOUT_CYC);
  localparam logic [CandW-1:0]  NumReqC  = CandW'(NUM_REQ);

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } state_e;

  state_e              state_q;
  logic [GrantW-1:0]   ptr_q;
  logic [GrantW-1:0]   grant_q;
  logic [BurstW-1:0]   burst_cnt_q;
  logic [IdleW-1:0]    idle_cnt_q;
  logic                busy_q;
  logic                timeout_err_q;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                lock;
  logic                cur_valid;
  logic                cur_last;
  logic [DATA_W-1:0]   cur_data;
  logic                xfer;
  logic                rel_last;
  logic                rel_burst;
  logic                rel_timeout;
  logic [GrantW-1:0]   next_ptr;
  logic                win_found;
  logic [GrantW-1:0]   win_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign lock      = (state_q == StLock);
  assign cur_valid = req_valid[grant_q];
  assign cur_last  = req_last[grant_q];
  assign cur_data  = req_bytes[grant_q];

  // Owner's handshake is forwarded combinationally; nothing moves while idle.
  assign tx_valid = lock & cur_valid;
  assign tx_data  = lock ? cur_data : '0;

  always_comb begin
    req_ready = '0;
    if (lock) begin
      req_ready[grant_q] = tx_ready;
    end
  end

  assign xfer        = tx_valid & tx_ready;
  assign rel_last    = xfer & cur_last;
  assign rel_burst   = xfer & (burst_cnt_q == BurstLim);
  // A transfer clears the idle count, so this can never coincide with xfer.
  assign rel_timeout = lock & ~cur_valid & (idle_cnt_q == IdleLim);

  // The releasing requester drops to lowest priority.
  assign next_ptr = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

  // First valid requester at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [CandW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + CandW'(off);
      if (cand >= NumReqC) begin
        cand = cand - NumReqC;
      end
      if (!win_found && req_valid[cand[GrantW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GrantW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      burst_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_q     <= win_idx;
            busy_q      <= 1'b1;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            state_q     <= StLock;
          end
        end
        StLock: begin
          if (rel_last || rel_burst || rel_timeout) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            ptr_q         <= next_ptr;
            timeout_err_q <= rel_timeout;
          end
          if (xfer) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            idle_cnt_q  <= '0;
          end else if (cur_valid) begin
            // Owner is waiting on the UART, not stalling: restart the idle run.
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
